// File: rtl/fc_rx_deframer.sv
// rtl/fc_rx_deframer.sv - Fibre Channel receive deframer with output buffer
//
// Purpose: hunts for SOF ordered sets on a word-aligned PHY stream, forwards
// frame words (SOF..EOF) into an output FIFO as Avalon-ST packets, and replaces
// damaged or truncated frames with a single error-flagged end-of-packet beat.
//
// Ports:
//   clk, reset_n                 - single clock, asynchronous active-low reset
//   rx_data[31:0], rx_datak[3:0] - PHY word and K-flags ([31:24] first on wire)
//   rx_valid                     - word qualifier (no backpressure to PHY)
//   rx_active                    - link framer is in state AC
//   out_*                        - Avalon-ST source, readyLatency 0
//   r_rdy                        - one-cycle pulse per received R_RDY
//   frame_cnt                    - good frames, wrapping
//   err_cnt                      - errors, saturating
module fc_rx_deframer #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_WORDS  = 537
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] rx_data,
    input  logic [3:0]  rx_datak,
    input  logic        rx_valid,
    input  logic        rx_active,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic        out_error,
    output logic        r_rdy,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int WCW = $clog2(MAX_WORDS + 1);
    localparam logic [WCW-1:0] WC_LIMIT  = WCW'(MAX_WORDS - 1);
    localparam logic [AW:0]    FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_HUNT  = 2'd0;
    localparam logic [1:0] ST_FRAME = 2'd1;
    localparam logic [1:0] ST_CLOSE = 2'd2;
    localparam logic [1:0] ST_DROP  = 2'd3;

    // FIFO entry: {sop, eop, error, data}
    localparam logic [34:0] ABORT_WORD = {1'b0, 1'b1, 1'b1, 32'h0};

    // Input stage: one register between the PHY and the state machine
    logic        in_valid_q,  in_valid_d;
    logic [31:0] in_data_q,   in_data_d;
    logic [3:0]  in_datak_q,  in_datak_d;
    logic        in_active_q, in_active_d;
    logic        r_rdy_q,     r_rdy_d;

    logic [1:0]     state_q,     state_d;
    logic [WCW-1:0] wc_q,        wc_d;
    logic           eof_seen_q,  eof_seen_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic [15:0]    err_cnt_q,   err_cnt_d;

    logic [34:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q,  count_d;

    logic        is_ctl, is_sof, is_eof, is_rrdy, is_os, is_data, is_cerr;
    logic        acc, pop, can_wr, wr_en, frame_inc, err_inc, eof_now, abort;
    logic [34:0] wr_word, head;

    always_comb begin
        in_valid_d  = rx_valid;
        in_data_d   = rx_data;
        in_datak_d  = rx_datak;
        in_active_d = rx_active;
        r_rdy_d     = rx_valid && (rx_datak == 4'b1000) && (rx_data == 32'hBC95_4A4A);
    end

    // Ordered-set classification of the staged word
    always_comb begin
        is_ctl  = (in_datak_q == 4'b1000) && (in_data_q[31:24] == 8'hBC);
        is_sof  = is_ctl && (in_data_q[23:16] == 8'hB5) &&
                  (in_data_q[15:0] inside {16'h5656, 16'h3636, 16'h5858, 16'h5555, 16'h3535});
        is_eof  = is_ctl && ((in_data_q[23:16] == 8'h95) || (in_data_q[23:16] == 8'hB5)) &&
                  ((in_data_q[15:0] == 16'h7575) || (in_data_q[15:0] == 16'hD5D5));
        is_rrdy = is_ctl && (in_data_q == 32'hBC95_4A4A);
        is_os   = is_ctl && !is_sof && !is_eof && !is_rrdy;
        is_data = (in_datak_q == 4'b0000);
        is_cerr = !is_ctl && !is_data;
        acc     = in_valid_q;
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    // A same-cycle read frees the slot for this cycle's write
    assign can_wr    = (count_q != FIFO_FULL) || pop;

    always_comb begin
        state_d    = state_q;
        wc_d       = wc_q;
        eof_seen_d = eof_seen_q;
        wr_en      = 1'b0;
        wr_word    = '0;
        frame_inc  = 1'b0;
        // A code error counts once per word, whatever else it causes
        err_inc    = acc && is_cerr;
        eof_now    = acc && is_eof;
        abort      = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (acc && is_sof && in_active_q) begin
                    if (can_wr) begin
                        wr_en   = 1'b1;
                        wr_word = {1'b1, 1'b0, 1'b0, in_data_q};
                        wc_d    = WCW'(1);
                        state_d = ST_FRAME;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            ST_FRAME: begin
                if (acc) begin
                    abort = !in_active_q || is_sof || is_rrdy || is_os || is_cerr ||
                            (is_data && (wc_q == WC_LIMIT));
                    if (abort) begin
                        err_inc = 1'b1;
                        wc_d    = '0;
                        if (can_wr) begin
                            wr_en   = 1'b1;
                            wr_word = ABORT_WORD;
                            state_d = ST_HUNT;
                        end else begin
                            eof_seen_d = 1'b0;
                            state_d    = ST_CLOSE;
                        end
                    end else if (is_data) begin
                        if (can_wr) begin
                            wr_en   = 1'b1;
                            wr_word = {1'b0, 1'b0, 1'b0, in_data_q};
                            wc_d    = wc_q + WCW'(1);
                        end else begin
                            err_inc    = 1'b1;
                            wc_d       = '0;
                            eof_seen_d = 1'b0;
                            state_d    = ST_CLOSE;
                        end
                    end else begin
                        // Only EOF remains; if it cannot be stored the frame has
                        // still ended, so CLOSE must not wait for another EOF.
                        wc_d = '0;
                        if (can_wr) begin
                            wr_en     = 1'b1;
                            wr_word   = {1'b0, 1'b1, 1'b0, in_data_q};
                            frame_inc = 1'b1;
                            state_d   = ST_HUNT;
                        end else begin
                            err_inc    = 1'b1;
                            eof_seen_d = 1'b1;
                            state_d    = ST_CLOSE;
                        end
                    end
                end
            end
            ST_CLOSE: begin
                if (eof_now) begin
                    eof_seen_d = 1'b1;
                end
                if (can_wr) begin
                    wr_en   = 1'b1;
                    wr_word = ABORT_WORD;
                    state_d = (eof_seen_q || eof_now) ? ST_HUNT : ST_DROP;
                end
            end
            ST_DROP: begin
                if (eof_now) begin
                    state_d = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
        frame_cnt_d = frame_inc ? frame_cnt_q + 16'd1 : frame_cnt_q;
        err_cnt_d   = (err_inc && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_valid_q  <= 1'b0;
            in_data_q   <= '0;
            in_datak_q  <= '0;
            in_active_q <= 1'b0;
            r_rdy_q     <= 1'b0;
            state_q     <= ST_HUNT;
            wc_q        <= '0;
            eof_seen_q  <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            in_valid_q  <= in_valid_d;
            in_data_q   <= in_data_d;
            in_datak_q  <= in_datak_d;
            in_active_q <= in_active_d;
            r_rdy_q     <= r_rdy_d;
            state_q     <= state_d;
            wc_q        <= wc_d;
            eof_seen_q  <= eof_seen_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage array carries no reset; outputs are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    assign out_data          = out_valid ? head[31:0] : 32'h0;
    assign out_startofpacket = out_valid && head[34];
    assign out_endofpacket   = out_valid && head[33];
    assign out_error         = out_valid && head[32];
    assign r_rdy             = r_rdy_q;
    assign frame_cnt         = frame_cnt_q;
    assign err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_fc_rx_deframer.sv
// tb/tb_fc_rx_deframer.sv - scoreboard testbench for fc_rx_deframer
module tb_fc_rx_deframer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] rx_data;
    logic [3:0]  rx_datak;
    logic        rx_valid;
    logic        rx_active;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic        out_error;
    logic        r_rdy;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    logic [34:0] exp_q [$];
    logic [34:0] mon_e;
    int          vec_cnt  = 0;
    int          miss_cnt = 0;
    int          rrdy_cnt = 0;

    localparam logic [31:0] SOF_W  = 32'hBCB5_5656;
    localparam logic [31:0] EOF_W  = 32'hBC95_7575;
    localparam logic [31:0] RRDY_W = 32'hBC95_4A4A;

    always #5 clk = ~clk;

    fc_rx_deframer #(.FIFO_DEPTH(16), .MAX_WORDS(537)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .rx_data           (rx_data),
        .rx_datak          (rx_datak),
        .rx_valid          (rx_valid),
        .rx_active         (rx_active),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_error         (out_error),
        .r_rdy             (r_rdy),
        .frame_cnt         (frame_cnt),
        .err_cnt           (err_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected beat per transfer
    always @(negedge clk) begin
        if (r_rdy) rrdy_cnt++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL unexpected_beat: got %0h expected none",
                         {out_startofpacket, out_endofpacket, out_error, out_data});
            end else begin
                mon_e = exp_q.pop_front();
                check("beat", {out_startofpacket, out_endofpacket, out_error, out_data}, mon_e);
            end
        end
    end

    task automatic push(input logic sop, input logic eop, input logic err, input logic [31:0] d);
        exp_q.push_back({sop, eop, err, d});
    endtask

    task automatic push_abort();
        push(1'b0, 1'b1, 1'b1, 32'h0);
    endtask

    task automatic put(input logic [31:0] d, input logic [3:0] k, input logic a);
        rx_data   = d;
        rx_datak  = k;
        rx_active = a;
        rx_valid  = 1'b1;
        @(posedge clk);
        #1;
        rx_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        idle(4);
        check({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        reset_n   = 1'b0;
        rx_data   = '0;
        rx_datak  = '0;
        rx_valid  = 1'b0;
        rx_active = 1'b1;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_r_rdy", r_rdy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);

        // Good frame with latency check
        push(1'b1, 1'b0, 1'b0, SOF_W);
        for (int i = 1; i <= 9; i++) push(1'b0, 1'b0, 1'b0, 32'hF00F_0000 + 32'(i));
        push(1'b0, 1'b1, 1'b0, EOF_W);
        put(SOF_W, 4'b1000, 1'b1);
        check("lat_cycle1_valid", out_valid, 0);
        put(32'hF00F_0001, 4'b0000, 1'b1);
        check("lat_cycle2_valid", out_valid, 1);
        for (int i = 2; i <= 9; i++) put(32'hF00F_0000 + 32'(i), 4'b0000, 1'b1);
        put(EOF_W, 4'b1000, 1'b1);
        drain("good");
        check("good_frame_cnt", frame_cnt, 1);
        check("good_err_cnt", err_cnt, 0);

        // R_RDY in HUNT, then inside a frame
        put(RRDY_W, 4'b1000, 1'b1);
        idle(4);
        check("rrdy_hunt_pulses", rrdy_cnt, 1);
        check("rrdy_hunt_no_beat", out_valid, 0);
        check("rrdy_hunt_err_cnt", err_cnt, 0);
        push(1'b1, 1'b0, 1'b0, SOF_W);
        push(1'b0, 1'b0, 1'b0, 32'h0000_00A1);
        push(1'b0, 1'b0, 1'b0, 32'h0000_00A2);
        push_abort();
        put(SOF_W, 4'b1000, 1'b1);
        put(32'h0000_00A1, 4'b0000, 1'b1);
        put(32'h0000_00A2, 4'b0000, 1'b1);
        put(RRDY_W, 4'b1000, 1'b1);
        drain("rrdy_frame");
        check("rrdy_frame_pulses", rrdy_cnt, 2);
        check("rrdy_frame_err_cnt", err_cnt, 1);

        // Code error in HUNT, then a code-error abort counted once
        put(32'h1234_5678, 4'b0100, 1'b1);
        idle(3);
        check("cerr_hunt_err_cnt", err_cnt, 2);
        push(1'b1, 1'b0, 1'b0, 32'hBCB5_3535);
        push(1'b0, 1'b0, 1'b0, 32'h0000_00B1);
        push_abort();
        put(32'hBCB5_3535, 4'b1000, 1'b1);
        put(32'h0000_00B1, 4'b0000, 1'b1);
        put(32'h0000_00B2, 4'b0001, 1'b1);
        drain("cerr_frame");
        check("cerr_frame_err_cnt", err_cnt, 3);
        check("cerr_frame_frame_cnt", frame_cnt, 1);

        // Backpressure: 20-word frame into a 16-deep FIFO
        out_ready = 1'b0;
        push(1'b1, 1'b0, 1'b0, SOF_W);
        for (int i = 1; i <= 15; i++) push(1'b0, 1'b0, 1'b0, 32'h0000_0C00 + 32'(i));
        push_abort();
        put(SOF_W, 4'b1000, 1'b1);
        for (int i = 1; i <= 18; i++) put(32'h0000_0C00 + 32'(i), 4'b0000, 1'b1);
        put(EOF_W, 4'b1000, 1'b1);
        idle(3);
        check("bp_err_cnt", err_cnt, 4);
        check("bp_head_sop", out_startofpacket, 1);
        out_ready = 1'b1;
        drain("bp_flush");
        push(1'b1, 1'b0, 1'b0, SOF_W);
        push(1'b0, 1'b0, 1'b0, 32'h0000_00D1);
        push(1'b0, 1'b0, 1'b0, 32'h0000_00D2);
        push(1'b0, 1'b1, 1'b0, 32'hBCB5_D5D5);
        put(SOF_W, 4'b1000, 1'b1);
        put(32'h0000_00D1, 4'b0000, 1'b1);
        put(32'h0000_00D2, 4'b0000, 1'b1);
        put(32'hBCB5_D5D5, 4'b1000, 1'b1);
        drain("bp_next");
        check("bp_frame_cnt", frame_cnt, 2);
        check("bp_err_cnt_after", err_cnt, 4);

        // Oversize: 600 data words, 535 fit after the SOF
        push(1'b1, 1'b0, 1'b0, SOF_W);
        for (int i = 1; i <= 535; i++) push(1'b0, 1'b0, 1'b0, 32'h5000_0000 + 32'(i));
        push_abort();
        put(SOF_W, 4'b1000, 1'b1);
        for (int i = 1; i <= 600; i++) put(32'h5000_0000 + 32'(i), 4'b0000, 1'b1);
        drain("oversize");
        check("oversize_err_cnt", err_cnt, 5);
        check("oversize_frame_cnt", frame_cnt, 2);

        // rx_active drop mid-frame, SOF ignored while inactive
        push(1'b1, 1'b0, 1'b0, SOF_W);
        for (int i = 1; i <= 3; i++) push(1'b0, 1'b0, 1'b0, 32'h0000_0E00 + 32'(i));
        push_abort();
        put(SOF_W, 4'b1000, 1'b1);
        for (int i = 1; i <= 3; i++) put(32'h0000_0E00 + 32'(i), 4'b0000, 1'b1);
        put(32'h0000_0E04, 4'b0000, 1'b0);
        put(SOF_W, 4'b1000, 1'b0);
        put(32'h0000_0E05, 4'b0000, 1'b0);
        put(EOF_W, 4'b1000, 1'b0);
        push(1'b1, 1'b0, 1'b0, 32'hBCB5_5858);
        push(1'b0, 1'b0, 1'b0, 32'h0000_00F1);
        push(1'b0, 1'b1, 1'b0, EOF_W);
        put(32'hBCB5_5858, 4'b1000, 1'b1);
        put(32'h0000_00F1, 4'b0000, 1'b1);
        put(EOF_W, 4'b1000, 1'b1);
        drain("inactive");
        check("inactive_err_cnt", err_cnt, 6);
        check("inactive_frame_cnt", frame_cnt, 3);

        // Reset pulse with a partial frame buffered
        out_ready = 1'b0;
        put(SOF_W, 4'b1000, 1'b1);
        put(32'h0000_0001, 4'b0000, 1'b1);
        put(32'h0000_0002, 4'b0000, 1'b1);
        idle(2);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_flags", {out_startofpacket, out_endofpacket, out_error, r_rdy}, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        check("mid_rst_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        idle(2);
        push(1'b1, 1'b0, 1'b0, SOF_W);
        push(1'b0, 1'b0, 1'b0, 32'h0000_0101);
        push(1'b0, 1'b0, 1'b0, 32'h0000_0102);
        push(1'b0, 1'b1, 1'b0, EOF_W);
        put(SOF_W, 4'b1000, 1'b1);
        put(32'h0000_0101, 4'b0000, 1'b1);
        put(32'h0000_0102, 4'b0000, 1'b1);
        put(EOF_W, 4'b1000, 1'b1);
        drain("post_rst");
        check("post_rst_frame_cnt", frame_cnt, 1);
        check("post_rst_err_cnt", err_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/fc_rx_deframer.md
FC_RX_DEFRAMER -- requirements
Module: fc_rx_deframer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning output buffer depth in words (power of two, at least 4).
REQ-002 SHALL have parameter MAX_WORDS, default 537, meaning maximum frame length in words including SOF and EOF.
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_data  in  32  word-aligned PHY RX word; [31:24] is the first byte on the wire.
REQ-006 SHALL have port rx_datak  in  4  control-character flags; bit 3 corresponds to [31:24].
REQ-007 SHALL have port rx_valid  in  1  rx_data/rx_datak qualifier; there is no backpressure toward the PHY.
REQ-008 SHALL have port rx_active  in  1  high while the link framer is in state AC.
REQ-009 SHALL have ports out_data (out, 32), out_valid (out, 1), out_ready (in, 1), out_startofpacket (out, 1), out_endofpacket (out, 1), out_error (out, 1), forming an Avalon-ST source with readyLatency 0.
REQ-010 SHALL have port r_rdy  out  1  one-cycle pulse per received R_RDY.
REQ-011 SHALL have port frame_cnt  out  16  count of good frames, wrapping.
REQ-012 SHALL have port err_cnt  out  16  count of errors, saturating at 0xFFFF.

Function
REQ-013 A word SHALL be "accepted" when rx_valid=1; all other cycles SHALL be ignored.
REQ-014 Classification of an accepted word:
- SOF: datak=4'b1000, [31:16]=BCB5, [15:0] in {5656, 3636, 5858, 5555, 3535}.
- EOF: datak=4'b1000, [31:24]=BC, [23:16] in {95, B5}, [15:0] in {7575, D5D5}.
- R_RDY: datak=4'b1000, word=BC954A4A.
- OTHER_OS: any other word with datak=4'b1000 and [31:24]=BC.
- DATA: datak=0.
- CODE_ERR: everything else.
REQ-015 The state machine SHALL have four states: HUNT, FRAME, CLOSE and DROP.
REQ-016 HUNT: a SOF accepted with rx_active=1 SHALL be written with sop=1, set wordcount to 1, and move to FRAME; all other words SHALL be discarded.
REQ-017 FRAME, DATA word: the word SHALL be written and wordcount incremented.
REQ-018 FRAME, EOF word: the word SHALL be written with eop=1, frame_cnt incremented, and the state SHALL return to HUNT.
REQ-019 FRAME abort conditions: SOF, R_RDY, OTHER_OS, CODE_ERR, rx_active=0, or a DATA word arriving when wordcount=MAX_WORDS-1.
REQ-020 On a FRAME abort, the block SHALL write the word 32'h0 with eop=1 and error=1, increment err_cnt, and move to HUNT; the offending word SHALL be dropped, including a SOF.
REQ-021 When a write is required and the FIFO is full, the word SHALL be dropped, err_cnt incremented, and the state SHALL move to CLOSE; a full FIFO in HUNT SHALL drop the SOF and remain in HUNT.
REQ-022 CLOSE: input SHALL be discarded; on the first cycle the FIFO is not full, the block SHALL write 32'h0 with eop=1 and error=1, then go to HUNT if an EOF was already discarded in CLOSE, otherwise go to DROP.
REQ-023 DROP: input SHALL be discarded until an EOF is accepted, then the state SHALL move to HUNT.
REQ-024 Each accepted R_RDY, in any state, SHALL raise r_rdy for exactly one cycle, on the cycle after acceptance.
REQ-025 CODE_ERR in any state SHALL increment err_cnt, once per word; an abort caused by that CODE_ERR SHALL count once, not twice.
REQ-026 Latency from an accepted word to out_valid SHALL be 2 cycles with the FIFO empty.
REQ-027 An output beat SHALL transfer on out_valid and out_ready; the FIFO SHALL support simultaneous read and write when full, with the read freeing space for that cycle's write.
REQ-028 Every emitted packet SHALL begin with sop and end with exactly one eop; the output SHALL never carry two sops without an intervening eop.

Reset
REQ-029 Asserting reset_n low SHALL asynchronously force HUNT, an empty FIFO, wordcount=0, out_valid/sop/eop/error=0, r_rdy=0, frame_cnt=0, and err_cnt=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no abort word emitted; after release the block SHALL resume hunting for SOF.

Verification
REQ-031 Good frame: SOF BCB55656, 9 DATA F00F0001..F00F0009, EOF BC957575, out_ready=1 -> 11 beats (sop on beat 1, eop on beat 11), first out_valid 2 cycles after SOF, frame_cnt=1, err_cnt=0.
REQ-032 R_RDY BC954A4A in HUNT -> one r_rdy pulse and no output beats; R_RDY inside a frame -> pulse, abort beat 0x0 with eop=1 and error=1, err_cnt=1.
REQ-033 Backpressure: out_ready=0 with FIFO_DEPTH=16 and a 20-word frame -> 16 beats buffered, err_cnt=1, CLOSE/DROP entered; out_ready=1 -> 16 beats then an abort beat with eop=1 and error=1; the next good frame is passed intact.
REQ-034 Oversize: SOF followed by 600 DATA words -> 536 beats then an abort beat, remaining words dropped, err_cnt=1.
REQ-035 rx_active dropped after 3 DATA words -> abort beat emitted; a SOF seen while rx_active=0 is ignored.
REQ-036 Reset pulse mid-frame -> all outputs 0 within the reset cycle, counters 0, and the next SOF..EOF frame is received correctly.
